// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage in front of a combinational program ROM.
// Reads an opcode byte and an operand byte, assembles them into ir and offers
// the result to the decoder through a valid/ready handshake. A jump from the
// execute stage redirects the PC in any state. The run input gates new fetches.
module fetch_unit #(
    parameter int                ADRS_W   = 8,
    parameter int                DATA_W   = 8,
    parameter logic [ADRS_W-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    output logic [ADRS_W-1:0]     rom_adrs,
    output logic                  rom_rd,
    input  logic [DATA_W-1:0]     rom_dout,
    output logic [2*DATA_W-1:0]   ir,
    output logic [ADRS_W-1:0]     op_pc,
    output logic                  ir_valid,
    input  logic                  ir_ready,
    input  logic                  jmp_en,
    input  logic [ADRS_W-1:0]     jmp_adrs
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        F_OP  = 2'd1,
        F_ARG = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [ADRS_W-1:0]    pc_q, pc_d;
    logic [2*DATA_W-1:0]  ir_q, ir_d;
    logic [ADRS_W-1:0]    op_pc_q, op_pc_d;
    logic                 ir_valid_q, ir_valid_d;

    // Next-state logic: a jump overrides everything, otherwise walk the fetch sequence.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        op_pc_d    = op_pc_q;
        ir_valid_d = ir_valid_q;

        if (jmp_en) begin
            pc_d       = jmp_adrs;
            ir_valid_d = 1'b0;
            state_d    = run ? F_OP : IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (run) begin
                        state_d = F_OP;
                    end
                end
                F_OP: begin
                    ir_d[2*DATA_W-1:DATA_W] = rom_dout;
                    op_pc_d                 = pc_q;
                    pc_d                    = pc_q + ADRS_W'(1);
                    state_d                 = F_ARG;
                end
                F_ARG: begin
                    ir_d[DATA_W-1:0] = rom_dout;
                    pc_d             = pc_q + ADRS_W'(1);
                    ir_valid_d       = 1'b1;
                    state_d          = HOLD;
                end
                HOLD: begin
                    if (ir_ready) begin
                        ir_valid_d = 1'b0;
                        state_d    = run ? F_OP : IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers; reset takes effect immediately, even mid-fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            op_pc_q    <= '0;
            ir_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            op_pc_q    <= op_pc_d;
            ir_valid_q <= ir_valid_d;
        end
    end

    assign rom_adrs = pc_q;
    assign rom_rd   = (state_q == F_OP) || (state_q == F_ARG);
    assign ir       = ir_q;
    assign op_pc    = op_pc_q;
    assign ir_valid = ir_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus for fetch_unit with a scoreboard queue of
// expected instructions, popped by a monitor on every decoder handshake.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        run;
    logic [7:0]  rom_adrs;
    logic        rom_rd;
    logic [7:0]  rom_dout;
    logic [15:0] ir;
    logic [7:0]  op_pc;
    logic        ir_valid;
    logic        ir_ready;
    logic        jmp_en;
    logic [7:0]  jmp_adrs;

    typedef struct {
        logic [15:0] ir;
        logic [7:0]  op_pc;
        int          gap;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] rom [256];
    int         assert_count = 0;
    int         fail_count   = 0;
    int         cycle        = 0;
    int         last_accept  = 0;

    fetch_unit #(.ADRS_W(8), .DATA_W(8), .RESET_PC(8'h00)) dut (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .rom_adrs (rom_adrs),
        .rom_rd   (rom_rd),
        .rom_dout (rom_dout),
        .ir       (ir),
        .op_pc    (op_pc),
        .ir_valid (ir_valid),
        .ir_ready (ir_ready),
        .jmp_en   (jmp_en),
        .jmp_adrs (jmp_adrs)
    );

    // Free-running clock, 10 time units per cycle
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Combinational ROM model; data is meaningless outside read cycles
    assign rom_dout = rom_rd ? rom[rom_adrs] : 8'hxx;

    // Cycle counter used to measure spacing between accepted instructions
    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic rdy, input logic j, input logic [7:0] ja);
        run      = r;
        ir_ready = rdy;
        jmp_en   = j;
        jmp_adrs = ja;
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pushExp(input logic [15:0] e_ir, input logic [7:0] e_pc, input int e_gap);
        exp_t e;
        e.ir    = e_ir;
        e.op_pc = e_pc;
        e.gap   = e_gap;
        exp_q.push_back(e);
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        tick(2);
        rst = 1'b0;
    endtask

    // Monitor: every handshake that is not overridden by a jump consumes one expected entry
    always @(negedge clk) begin
        if (!rst && ir_valid && ir_ready && !jmp_en) begin
            if (exp_q.size() == 0) begin
                assert_count++;
                fail_count++;
                $display("[TB] FAIL unexpected_handshake: got ir=%h op_pc=%h, expected no instruction", ir, op_pc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("sb_ir", ir, e.ir);
                checkOutput("sb_op_pc", {8'h00, op_pc}, {8'h00, e.op_pc});
                if (e.gap != 0) begin
                    checkOutput("sb_gap", 16'(cycle - last_accept), 16'(e.gap));
                end
            end
            last_accept = cycle;
        end
    end

    // Watchdog so the run always terminates
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected normal completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus sequence
    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 8'h5A;
        rom[8'h00] = 8'h01; rom[8'h01] = 8'h20; rom[8'h02] = 8'h05; rom[8'h03] = 8'h22;
        rom[8'h04] = 8'h03; rom[8'h05] = 8'h20; rom[8'h06] = 8'h05; rom[8'h07] = 8'h23;
        rom[8'h08] = 8'h02; rom[8'h09] = 8'h22; rom[8'h0A] = 8'h04; rom[8'h0B] = 8'h22;
        rom[8'hFF] = 8'hC7;

        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        tick(2);
        checkOutput("rst_rom_rd", {15'h0, rom_rd}, 16'h0000);
        checkOutput("rst_ir", ir, 16'h0000);
        checkOutput("rst_ir_valid", {15'h0, ir_valid}, 16'h0000);
        checkOutput("rst_op_pc", {8'h00, op_pc}, 16'h0000);
        checkOutput("rst_rom_adrs", {8'h00, rom_adrs}, 16'h0000);
        rst = 1'b0;

        // First fetch and free run through six instructions
        $display("[TB] free run from reset");
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        checkOutput("idle_rom_rd", {15'h0, rom_rd}, 16'h0000);
        pushExp(16'h0120, 8'h00, 0);
        pushExp(16'h0522, 8'h02, 3);
        pushExp(16'h0320, 8'h04, 3);
        pushExp(16'h0523, 8'h06, 3);
        pushExp(16'h0222, 8'h08, 3);
        pushExp(16'h0422, 8'h0A, 3);
        tick(1);
        checkOutput("fop_rom_adrs", {8'h00, rom_adrs}, 16'h0000);
        checkOutput("fop_rom_rd", {15'h0, rom_rd}, 16'h0001);
        tick(1);
        checkOutput("farg_rom_adrs", {8'h00, rom_adrs}, 16'h0001);
        checkOutput("farg_rom_rd", {15'h0, rom_rd}, 16'h0001);
        checkOutput("farg_ir_valid", {15'h0, ir_valid}, 16'h0000);
        tick(1);
        checkOutput("hold_ir_valid", {15'h0, ir_valid}, 16'h0001);
        checkOutput("hold_rom_rd", {15'h0, rom_rd}, 16'h0000);
        tick(1);
        checkOutput("next_rom_adrs", {8'h00, rom_adrs}, 16'h0002);
        checkOutput("next_rom_rd", {15'h0, rom_rd}, 16'h0001);
        tick(13);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        tick(2);
        checkOutput("stop_rom_rd", {15'h0, rom_rd}, 16'h0000);
        checkOutput("stop_rom_adrs", {8'h00, rom_adrs}, 16'h000C);
        checkOutput("stop_ir_valid", {15'h0, ir_valid}, 16'h0000);

        // Backpressure: decoder stalls for five cycles in HOLD
        $display("[TB] backpressure");
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        pushExp(16'h0120, 8'h00, 0);
        tick(3);
        for (int k = 0; k < 5; k++) begin
            checkOutput("bp_ir", ir, 16'h0120);
            checkOutput("bp_ir_valid", {15'h0, ir_valid}, 16'h0001);
            checkOutput("bp_rom_adrs", {8'h00, rom_adrs}, 16'h0002);
            checkOutput("bp_rom_rd", {15'h0, rom_rd}, 16'h0000);
            tick(1);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        tick(1);
        checkOutput("bp_after_valid", {15'h0, ir_valid}, 16'h0000);
        checkOutput("bp_after_rom_rd", {15'h0, rom_rd}, 16'h0000);
        checkOutput("bp_after_adrs", {8'h00, rom_adrs}, 16'h0002);

        // Jump during F_ARG discards the partial instruction
        $display("[TB] jump during operand fetch");
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        pushExp(16'h0222, 8'h08, 0);
        tick(2);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h08);
        tick(1);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        checkOutput("jmp_ir_valid", {15'h0, ir_valid}, 16'h0000);
        checkOutput("jmp_rom_adrs", {8'h00, rom_adrs}, 16'h0008);
        checkOutput("jmp_rom_rd", {15'h0, rom_rd}, 16'h0001);
        tick(5);
        // Now in HOLD with 0422; a jump in the same cycle as the handshake wins
        checkOutput("jmp_hold_ir", ir, 16'h0422);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h04);
        tick(1);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("jmpwin_ir_valid", {15'h0, ir_valid}, 16'h0000);
        checkOutput("jmpwin_rom_adrs", {8'h00, rom_adrs}, 16'h0004);
        checkOutput("jmpwin_rom_rd", {15'h0, rom_rd}, 16'h0000);

        // Stop requested in F_OP: fetch completes, then IDLE, then resume
        $display("[TB] run drop during opcode fetch");
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        tick(1);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        pushExp(16'h0320, 8'h04, 0);
        tick(3);
        for (int k = 0; k < 2; k++) begin
            checkOutput("halt_rom_rd", {15'h0, rom_rd}, 16'h0000);
            checkOutput("halt_rom_adrs", {8'h00, rom_adrs}, 16'h0006);
            tick(1);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        pushExp(16'h0523, 8'h06, 0);
        tick(3);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        tick(1);
        checkOutput("resume_idle_adrs", {8'h00, rom_adrs}, 16'h0008);

        // Address wrap: opcode at FF pairs with operand at 00
        $display("[TB] wrap and asynchronous reset");
        applyStimulus(1'b1, 1'b1, 1'b1, 8'hFF);
        tick(1);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        pushExp(16'hC701, 8'hFF, 0);
        checkOutput("wrap_adrs_ff", {8'h00, rom_adrs}, 16'h00FF);
        tick(1);
        checkOutput("wrap_adrs_00", {8'h00, rom_adrs}, 16'h0000);
        tick(1);
        checkOutput("wrap_adrs_01", {8'h00, rom_adrs}, 16'h0001);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        tick(1);
        checkOutput("wrap_idle_adrs", {8'h00, rom_adrs}, 16'h0001);

        // Reset asserted mid-F_ARG clears state without a clock edge
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        tick(2);
        checkOutput("pre_rst_ir", ir, 16'h2001);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_ir", ir, 16'h0000);
        checkOutput("arst_ir_valid", {15'h0, ir_valid}, 16'h0000);
        checkOutput("arst_rom_adrs", {8'h00, rom_adrs}, 16'h0000);
        checkOutput("arst_rom_rd", {15'h0, rom_rd}, 16'h0000);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        tick(2);
        rst = 1'b0;
        tick(1);

        checkOutput("sb_drained", 16'(exp_q.size()), 16'h0000);
        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
